pdp8l_pulse_fifo: RTL
=====================

Name: pdp8l_pulse_fifo

Overview:
Downstream consumer of the PDP-8/L pulse-bit generator's `pulse` output.
- Integrates `pulse` over a programmable sample period and produces one 8-bit audio sample per period.
- Packs four samples into each 32-bit word and buffers the words in a FIFO.
- The ARM processor drains the FIFO through the standard 4-register ARM register window, replacing the single-word sample latch with a buffered stream that cannot silently lose samples.

Parameters:
- DEPTH_LOG2, 6, log2 of FIFO depth in 32-bit words; legal range 2..10.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CSTEP  in  1  clock-step enable; all sampling/integration logic advances only when high
- armwrite  in  1  ARM register write strobe, one cycle
- armread  in  1  ARM register read strobe, one cycle; pops FIFO when armraddr==3
- armraddr  in  2  ARM read register select
- armwaddr  in  2  ARM write register select
- armwdata  in  32  ARM write data
- armrdata  out  32  ARM read data, combinational from armraddr
- pulse  in  1  pulse bit from pulse-bit generator
- irq  out  1  FIFO attention interrupt (see Optional Feature)

Behaviour:
Register map:
- [0] read 32'h50461001: 'PF', log2(nreg)-1=1, version 001. Writes ignored.
- [1] read/write {samprate[31:16], sampincr[15:0]}.
  - A write clears sampcount, sampinteg and the packer.
  - A write does not flush the FIFO.
- [2] read {enable[31], ovfsticky[30], 4'b0, ovfcount[25:16] (saturates at 1023), 5'b0, level[10:0]}.
  - Write: bit31 sets enable; bit30=1 clears ovfsticky and ovfcount; bit0=1 flushes the FIFO and packer.
  - A write to [2] also clears sampcount and sampinteg.
- [3] read returns head word, or 0 when empty.
  - armread with armraddr==3 and FIFO non-empty pops one word at end of that cycle.
  - Read of an empty FIFO does not pop and does not change level.

Reset: enable=0, samprate=0, sampincr=0, sampcount=0, sampinteg=0, packer empty, FIFO empty (level 0), ovfsticky=0, ovfcount=0, irq=0.

Sampling (only when CSTEP && enable; otherwise held):
- sampcount runs 0..samprate.
- Non-terminal cycle: sampcount+1; if pulse, sampinteg += sampincr, saturating at 16'hFFFF.
- Terminal cycle (sampcount==samprate):
  - emit sample byte = sampinteg[15:8];
  - sampcount<=0;
  - sampinteg <= pulse ? sampincr : 0.
- samprate=0: a sample is emitted every CSTEP cycle.

Packer:
- 2-bit byte index; first sample of a word goes to [7:0], then [15:8], [23:16], [31:24].
- The fourth byte pushes the completed word to the FIFO in the same cycle; the packer returns to empty.

FIFO:
- Power-of-two circular buffer; read/write pointers wrap modulo depth; level 0..depth.
- Push when full: word dropped, ovfsticky<=1, ovfcount increments (saturating), level stays at depth.
- Simultaneous push and pop: both take effect, level unchanged. This includes when full, where the push is accepted and no overflow is counted.
- Flush via [2] bit0: pointers and level to 0, packer cleared. If it coincides with a pop, the flush wins.
- Precedence when armwrite and sample emission coincide in one cycle: the register write wins, and that sample is discarded.
- Latency: pushed word readable at [3] on the cycle after the push.
- RESET in any cycle, including mid-period or mid-word, restores all reset values next cycle; contents lost.

Optional Feature:
PBFIFO_IRQ_EN
- Defined: irq is registered and high while enable && level >= 2^(DEPTH_LOG2-1) (half full) or ovfsticky is set. It updates one cycle after level/ovfsticky change and drops after the pop or clear that removes the condition.
- Undefined: irq tied 0; all other behaviour identical.

Test Plan:
1. Reset, then read [0], [1], [2], [3] -> 32'h50461001, 0, 0, 0; irq=0.
2. Write [1]=32'h00033FFF, [2]=32'h80000000, pulse held 1, CSTEP=1 for 16 cycles -> level 1; [3]=32'hFFFFFFBF (first sample 0xBF, then 0xFF×3); armread on [3] -> level 0.
3. Same setup with pulse held 0 for 16 cycles -> [3]=32'h00000000, level 1. Toggle CSTEP every other cycle -> exactly half the samples per wall-clock time.
4. DEPTH_LOG2=2, samprate=0, enable, pulse 1, 20 cycles with no reads -> level 4, ovfsticky=1, ovfcount=1. Write [2]=32'hC0000000 -> ovfsticky=0, ovfcount=0, level 4.
5. FIFO full with push and armread pop in the same cycle -> level stays 4, ovfcount unchanged, next head is the second-oldest word.
6. PBFIFO_IRQ_EN, DEPTH_LOG2=2 -> irq rises the cycle after level reaches 2 and falls after pops bring level to 1. RESET mid-word (byte index 2) -> level 0, next completed word built entirely from new samples.

Source files
------------

// File: rtl/pdp8l_pulse_fifo.sv
// Pulse integrator -> 4-sample word packer -> circular FIFO, drained through the ARM register window.
// Optional macro PBFIFO_IRQ_EN enables the half-full / overflow interrupt; otherwise irq is tied low.
module pdp8l_pulse_fifo #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        CSTEP,
    input  logic        armwrite,
    input  logic        armread,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        pulse,
    output logic        irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic                  enable;
    logic                  ovfsticky;
    logic [9:0]            ovfcount;
    logic [15:0]           samprate;
    logic [15:0]           sampincr;
    logic [15:0]           sampcount;
    logic [15:0]           sampinteg;
    logic [1:0]            byteidx;
    logic [23:0]           pack;
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [LW-1:0]         level;
    logic [31:0]           mem [DEPTH];

    logic        wr1, wr2, flush, step, terminal, emit, push, pop;
    logic        full, empty, accept, overflow;
    logic [7:0]  sample;
    logic [16:0] integ_sum;
    logic [15:0] integ_next;

    assign wr1      = armwrite && (armwaddr == 2'd1);
    assign wr2      = armwrite && (armwaddr == 2'd2);
    assign flush    = wr2 && armwdata[0];
    // Any register write stalls the sampler, so a coinciding sample is discarded.
    assign step     = CSTEP && enable && !armwrite;
    assign terminal = (sampcount == samprate);
    assign emit     = step && terminal;
    assign push     = emit && (byteidx == 2'd3);
    assign sample   = sampinteg[15:8];

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign pop      = armread && (armraddr == 2'd3) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign accept   = push && (!full || pop);
    assign overflow = push && full && !pop;

    assign integ_sum  = {1'b0, sampinteg} + {1'b0, sampincr};
    assign integ_next = integ_sum[16] ? 16'hFFFF : integ_sum[15:0];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            enable    <= 1'b0;
            samprate  <= '0;
            sampincr  <= '0;
            sampcount <= '0;
            sampinteg <= '0;
            byteidx   <= '0;
            pack      <= '0;
            ovfsticky <= 1'b0;
            ovfcount  <= '0;
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
        end else begin
            if (wr1) begin
                samprate  <= armwdata[31:16];
                sampincr  <= armwdata[15:0];
                sampcount <= '0;
                sampinteg <= '0;
                byteidx   <= '0;
                pack      <= '0;
            end else if (wr2) begin
                enable    <= armwdata[31];
                sampcount <= '0;
                sampinteg <= '0;
                if (armwdata[0]) begin
                    byteidx <= '0;
                    pack    <= '0;
                end
            end else if (step) begin
                if (terminal) begin
                    sampcount <= '0;
                    sampinteg <= pulse ? sampincr : 16'h0000;
                    byteidx   <= byteidx + 2'd1;
                    case (byteidx)
                        2'd0:    pack[7:0]   <= sample;
                        2'd1:    pack[15:8]  <= sample;
                        2'd2:    pack[23:16] <= sample;
                        default: ;
                    endcase
                end else begin
                    sampcount <= sampcount + 16'd1;
                    if (pulse) sampinteg <= integ_next;
                end
            end

            if (wr2 && armwdata[30]) begin
                ovfsticky <= 1'b0;
                ovfcount  <= '0;
            end else if (overflow) begin
                ovfsticky <= 1'b1;
                if (ovfcount != 10'h3FF) ovfcount <= ovfcount + 10'd1;
            end

            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (accept) wptr <= wptr + 1'b1;
                if (pop)    rptr <= rptr + 1'b1;
                if (accept && !pop)      level <= level + 1'b1;
                else if (pop && !accept) level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (accept && !RESET) mem[wptr] <= {sample, pack};
    end

    always_comb begin
        armrdata = 32'h0;
        case (armraddr)
            2'd0: armrdata = 32'h50461001;
            2'd1: armrdata = {samprate, sampincr};
            2'd2: armrdata = {enable, ovfsticky, 4'b0, ovfcount, 5'b0, 11'(level)};
            2'd3: armrdata = empty ? 32'h0 : mem[rptr];
            default: armrdata = 32'h0;
        endcase
    end

`ifdef PBFIFO_IRQ_EN
    always_ff @(posedge CLOCK) begin
        if (RESET) irq <= 1'b0;
        else       irq <= (enable && (level >= LW'(DEPTH / 2))) || ovfsticky;
    end
`else
    assign irq = 1'b0;
`endif

endmodule
